// File: rtl/qspi_pkg.sv
// qspi_pkg: opcodes, FSM states and chip-select targets shared by the QSPI arbiter and its bench.
package qspi_pkg;
    localparam logic [7:0] QSPI_CMD_READ  = 8'h0B;
    localparam logic [7:0] QSPI_CMD_WRITE = 8'h02;
    typedef enum logic [2:0] {IDLE, CMD, DUMMY, DATA, DESEL, ERR} state_e;
    typedef enum logic [1:0] {FLASH, RAM_A, RAM_B} target_e;
    function automatic target_e target_of(input logic [24:0] addr);
        target_e t;
        if (!addr[24]) t = FLASH;
        else if (addr[23]) t = RAM_B;
        else t = RAM_A;
        return t;
    endfunction
endpackage

// File: rtl/qspi_rr_arbiter.sv
// qspi_rr_arbiter: two-way round-robin grant between the fetch and data ports.
module qspi_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic fetch_req_i,
    input  logic data_req_i,
    output logic fetch_gnt_o,
    output logic data_gnt_o
);
    logic prio_data_q;
    assign data_gnt_o  = en_i && data_req_i && (!fetch_req_i || prio_data_q);
    assign fetch_gnt_o = en_i && fetch_req_i && !data_gnt_o;
    always_ff @(posedge clk) begin
        if (rst) prio_data_q <= 1'b1;
        else if (data_gnt_o || fetch_gnt_o) prio_data_q <= fetch_gnt_o;
    end
endmodule

// File: rtl/qspi_arbiter_ctrl.sv
// qspi_arbiter_ctrl: shares one quad-SPI bus between an instruction-fetch port and a data port,
// running single-byte command/address/dummy/data frames at clk/2.
module qspi_arbiter_ctrl
    import qspi_pkg::*;
#(
    parameter int          DUMMY_NIBBLES = 4,
    parameter int          DESEL_CYCLES  = 2,
    parameter logic [7:0]  CMD_READ      = QSPI_CMD_READ,
    parameter logic [7:0]  CMD_WRITE     = QSPI_CMD_WRITE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [23:0] fetch_addr,
    output logic [7:0]  fetch_rdata,
    output logic        fetch_ready,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [24:0] data_addr,
    input  logic [7:0]  data_wdata,
    output logic [7:0]  data_rdata,
    output logic        data_ready,
    output logic        data_err,
    output logic        qspi_clk,
    output logic [3:0]  qspi_data_out,
    output logic [3:0]  qspi_data_oe,
    input  logic [3:0]  qspi_data_in,
    output logic        qspi_flash_select,
    output logic        qspi_ram_a_select,
    output logic        qspi_ram_b_select
);
    state_e      state_q, state_d;
    target_e     tgt_q, tgt_d;
    logic        phase_q, phase_d;
    logic [3:0]  nib_q, nib_d, cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  wdata_q, wdata_d, frdata_q, frdata_d, drdata_q, drdata_d;
    logic        we_q, we_d, port_q, port_d;
    logic        fready_q, fready_d, dready_q, dready_d, derr_q, derr_d;
    logic        fetch_gnt, data_gnt, active, drive, nib_end;
    logic [3:0]  nib_last;

    qspi_rr_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == IDLE),
        .fetch_req_i (fetch_req),
        .data_req_i  (data_req),
        .fetch_gnt_o (fetch_gnt),
        .data_gnt_o  (data_gnt)
    );

    assign nib_last = state_q == CMD ? 4'd7 : (state_q == DUMMY ? 4'(DUMMY_NIBBLES - 1) : 4'd1);
    assign nib_end  = phase_q && nib_q == nib_last;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        phase_d  = phase_q;
        nib_d    = nib_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        wdata_d  = wdata_q;
        frdata_d = frdata_q;
        drdata_d = drdata_q;
        we_d     = we_q;
        port_d   = port_q;
        fready_d = 1'b0;
        dready_d = 1'b0;
        derr_d   = 1'b0;
        case (state_q)
            IDLE: if (fetch_gnt || data_gnt) begin
                port_d  = data_gnt;
                we_d    = data_gnt && data_we;
                tgt_d   = FLASH;
                if (data_gnt) tgt_d = target_of(data_addr);
                wdata_d = data_wdata;
                sh_d    = {(data_gnt && data_we) ? CMD_WRITE : CMD_READ, data_gnt ? data_addr[23:0] : fetch_addr};
                phase_d = 1'b0;
                nib_d   = 4'd0;
                cnt_d   = 4'd0;
                state_d = CMD;
                // Writes to flash are refused without touching the bus.
                if (we_d && tgt_d == FLASH) begin
                    state_d  = ERR;
                    dready_d = 1'b1;
                    derr_d   = 1'b1;
                end
            end
            CMD, DUMMY, DATA: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    nib_d = nib_end ? 4'd0 : nib_q + 4'd1;
                    if (state_q != DUMMY) sh_d = {sh_q[27:0], qspi_data_in};
                end
                if (nib_end && state_q == DATA) begin
                    state_d  = DESEL;
                    fready_d = !port_q;
                    dready_d = port_q;
                    if (!port_q) frdata_d = {sh_q[3:0], qspi_data_in};
                    if (port_q && !we_q) drdata_d = {sh_q[3:0], qspi_data_in};
                end else if (nib_end) begin
                    state_d = DATA;
                    if (state_q == CMD && !we_q && DUMMY_NIBBLES > 0) state_d = DUMMY;
                    sh_d = {wdata_q, 24'h0};
                end
            end
            DESEL, ERR: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(DESEL_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tgt_q    <= FLASH;
            phase_q  <= 1'b0;
            nib_q    <= 4'd0;
            cnt_q    <= 4'd0;
            sh_q     <= 32'h0;
            wdata_q  <= 8'h0;
            frdata_q <= 8'h0;
            drdata_q <= 8'h0;
            we_q     <= 1'b0;
            port_q   <= 1'b0;
            fready_q <= 1'b0;
            dready_q <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            phase_q  <= phase_d;
            nib_q    <= nib_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            wdata_q  <= wdata_d;
            frdata_q <= frdata_d;
            drdata_q <= drdata_d;
            we_q     <= we_d;
            port_q   <= port_d;
            fready_q <= fready_d;
            dready_q <= dready_d;
            derr_q   <= derr_d;
        end
    end

    assign active            = state_q inside {CMD, DUMMY, DATA};
    assign drive             = state_q == CMD || (state_q == DATA && we_q);
    assign qspi_clk          = active && phase_q;
    assign qspi_data_oe      = {4{drive}};
    assign qspi_data_out     = drive ? sh_q[31:28] : 4'h0;
    assign qspi_flash_select = !(active && tgt_q == FLASH);
    assign qspi_ram_a_select = !(active && tgt_q == RAM_A);
    assign qspi_ram_b_select = !(active && tgt_q == RAM_B);
    assign fetch_ready       = fready_q;
    assign fetch_rdata       = frdata_q;
    assign data_ready        = dready_q;
    assign data_rdata        = drdata_q;
    assign data_err          = derr_q;
endmodule

// File: tb/tb_qspi_arbiter_ctrl.sv
// tb_qspi_arbiter_ctrl: directed tests against a transaction-level model of the shared QSPI
// controller, with a bench-side memory that answers read frames on qspi_data_in.
module tb_qspi_arbiter_ctrl;
    localparam int D      = 4;
    localparam int DS     = 2;
    localparam int RD_LAT = 1 + 2 * (8 + D + 2);
    localparam int WR_LAT = 1 + 2 * 10;

    logic        clk = 1'b0, rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [23:0] fetch_addr = '0;
    logic [7:0]  fetch_rdata, data_rdata;
    logic        fetch_ready, data_ready, data_err;
    logic        data_req = 1'b0, data_we = 1'b0;
    logic [24:0] data_addr = '0;
    logic [7:0]  data_wdata = '0;
    logic        qspi_clk, qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select;
    logic [3:0]  qspi_data_out, qspi_data_oe;
    logic [3:0]  qspi_data_in = '0;

    qspi_arbiter_ctrl #(.DUMMY_NIBBLES(D), .DESEL_CYCLES(DS)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata), .fetch_ready(fetch_ready),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ready(data_ready), .data_err(data_err),
        .qspi_clk(qspi_clk), .qspi_data_out(qspi_data_out), .qspi_data_oe(qspi_data_oe),
        .qspi_data_in(qspi_data_in), .qspi_flash_select(qspi_flash_select),
        .qspi_ram_a_select(qspi_ram_a_select), .qspi_ram_b_select(qspi_ram_b_select)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0] mem [logic [24:0]];

    bit          busy = 0, m_port = 0, m_we = 0, prio_data = 1, chk_en = 0;
    int          g = 0, lat = 0, free_at = 0;
    logic [24:0] m_key = '0;
    logic [7:0]  m_wdata = '0, m_rv = '0, exp_fr = '0, exp_dr = '0;

    logic [47:0] cap = '0;
    logic [7:0]  ord = '0;
    int          f_low = 0, a_low = 0, b_low = 0, oe_cyc = 0, nrdy = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: who is granted when, how long it takes and what it returns.
    always @(posedge clk) begin
        if (rst) begin
            busy = 0; prio_data = 1; free_at = cyc + 1; exp_fr = '0; exp_dr = '0;
        end else begin
            if (busy && cyc == g + lat) begin
                busy = 0;
                if (!m_we && m_port) exp_dr = m_rv;
                if (!m_port) exp_fr = m_rv;
            end
            if (!busy && cyc >= free_at && (fetch_req || data_req)) begin
                m_port    = data_req && (!fetch_req || prio_data);
                prio_data = !m_port;
                m_key     = m_port ? data_addr : {1'b0, fetch_addr};
                m_we      = m_port && data_we;
                m_wdata   = data_wdata;
                lat       = !m_we ? RD_LAT : (m_key[24] ? WR_LAT : 1);
                m_rv      = mem.exists(m_key) ? mem[m_key] : 8'h00;
                if (m_we && m_key[24]) mem[m_key] = m_wdata;
                g = cyc; free_at = g + lat + DS; busy = 1;
            end
        end
        cyc++;
    end

    // Bus slave plus per-cycle comparison; k is the cycle offset from the grant.
    always @(negedge clk) begin
        int k, n;
        bit act, drv, rdy;
        logic [31:0] cmd;
        k   = cyc - g;
        n   = (k - 1) / 2;
        act = busy && k >= 1 && k < lat;
        drv = act && (m_we || n < 8);
        rdy = busy && k == lat;
        cmd = {m_we ? 8'h02 : 8'h0B, m_key[23:0]};
        qspi_data_in = (act && !m_we && n >= 8 + D) ? (n == 8 + D ? m_rv[7:4] : m_rv[3:0]) : 4'(cyc * 7 + 3);
        if (chk_en) begin
            chk("qspi_clk", qspi_clk, act && (k % 2 == 0));
            chk("qspi_data_oe", qspi_data_oe, drv ? 4'hF : 4'h0);
            if (drv) chk("qspi_data_out", qspi_data_out, n < 8 ? 4'(cmd >> (4 * (7 - n))) : (n == 8 ? m_wdata[7:4] : m_wdata[3:0]));
            chk("flash_select", qspi_flash_select, !(act && !m_key[24]));
            chk("ram_a_select", qspi_ram_a_select, !(act && m_key[24:23] == 2'b10));
            chk("ram_b_select", qspi_ram_b_select, !(act && m_key[24:23] == 2'b11));
            chk("fetch_ready", fetch_ready, rdy && !m_port);
            chk("data_ready", data_ready, rdy && m_port);
            chk("data_err", data_err, rdy && m_we && !m_key[24]);
            chk("fetch_rdata", fetch_rdata, (rdy && !m_port) ? m_rv : exp_fr);
            chk("data_rdata", data_rdata, (rdy && m_port && !m_we) ? m_rv : exp_dr);
        end
    end

    always @(negedge clk) begin
        if (qspi_clk && qspi_data_oe == 4'hF) cap = {cap[43:0], qspi_data_out};
        if (!qspi_flash_select) f_low++;
        if (!qspi_ram_a_select) a_low++;
        if (!qspi_ram_b_select) b_low++;
        if (qspi_data_oe != 4'h0) oe_cyc++;
        if (fetch_ready || data_ready) begin
            nrdy++;
            ord = {ord[6:0], data_ready};
        end
    end

    task automatic clr();
        cap = '0; ord = '0; f_low = 0; a_low = 0; b_low = 0; oe_cyc = 0; nrdy = 0;
    endtask

    task automatic wait_rdy(input bit port, output int tr, output logic err);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? data_ready : fetch_ready) && n < 200);
        chk(port ? "data_ready within bound" : "fetch_ready within bound", port ? data_ready : fetch_ready, 1'b1);
        tr = cyc;
        err = data_err;
    endtask

    task automatic run_fetch(input logic [23:0] a, output int t0, output int tr);
        logic e;
        @(posedge clk); #1;
        fetch_addr = a; fetch_req = 1'b1; t0 = cyc;
        wait_rdy(1'b0, tr, e);
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    task automatic run_data(input logic we, input logic [24:0] a, input logic [7:0] wd,
                            output int t0, output int tr, output logic err);
        @(posedge clk); #1;
        data_we = we; data_addr = a; data_wdata = wd; data_req = 1'b1; t0 = cyc;
        wait_rdy(1'b1, tr, err);
        @(posedge clk); #1;
        data_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, tr, t1, n;
        logic e;
        mem[25'h0000123] = 8'h5A;
        mem[25'h1800020] = 8'h3C;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; chk_en = 1;
        @(negedge clk);
        chk("reset selects", {qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select}, 3'b111);
        chk("reset bus", {qspi_clk, qspi_data_oe, qspi_data_out}, 9'h0);
        chk("reset port outputs", {fetch_ready, data_ready, data_err, fetch_rdata, data_rdata}, 19'h0);

        // Both ports requesting continuously: data first after reset, then alternating.
        clr();
        @(posedge clk); #1;
        fetch_addr = 24'h000123; data_addr = 25'h1000010; data_we = 1'b0;
        fetch_req = 1'b1; data_req = 1'b1;
        n = 0;
        while (nrdy < 4 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1 fetch_req = 1'b0; data_req = 1'b0;
        chk("rr ready count", nrdy, 4);
        chk("rr order", ord[3:0], 4'b1010);

        clr();
        run_fetch(24'h000123, t0, tr);
        chk("fetch latency", tr - t0, 29);
        chk("fetch rdata", fetch_rdata, 8'h5A);
        chk("fetch nibbles", cap[31:0], 32'h0B000123);
        chk("fetch flash low cycles", f_low, 28);
        chk("fetch ram low cycles", a_low + b_low, 0);

        clr();
        run_data(1'b1, 25'h1000010, 8'hC3, t0, tr, e);
        chk("ram_a write latency", tr - t0, 21);
        chk("ram_a write frame", cap[39:0], 40'h02000010C3);
        chk("ram_a write a low", a_low, 20);
        chk("ram_a write others low", f_low + b_low, 0);
        chk("ram_a write err", e, 1'b0);
        clr();
        run_data(1'b0, 25'h1000010, 8'h00, t0, tr, e);
        chk("ram_a read latency", tr - t0, 29);
        chk("ram_a read rdata", data_rdata, 8'hC3);
        chk("ram_a read frame", cap[31:0], 32'h0B000010);
        chk("ram_a read others low", f_low + b_low, 0);

        clr();
        run_data(1'b1, 25'h0000040, 8'h99, t0, tr, e);
        chk("flash write latency", tr - t0, 1);
        chk("flash write err", e, 1'b1);
        chk("flash write selects low", f_low + a_low + b_low, 0);

        // Reset ten cycles into a RAM B read drops it without a ready pulse.
        clr();
        @(posedge clk); #1;
        data_we = 1'b0; data_addr = 25'h1800020; data_req = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1; data_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort selects", {qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select}, 3'b111);
        chk("abort qspi_clk", qspi_clk, 1'b0);
        chk("abort b low cycles", b_low, 10);
        repeat (40) @(negedge clk);
        chk("abort no ready", nrdy, 0);
        run_data(1'b0, 25'h1800020, 8'h00, t0, tr, e);
        chk("post-reset latency", tr - t0, 29);
        chk("post-reset rdata", data_rdata, 8'h3C);

        clr();
        run_data(1'b1, 25'h1800007, 8'hA5, t0, tr, e);
        chk("ram_b write latency", tr - t0, 21);
        chk("ram_b write frame", cap[39:0], 40'h02800007A5);
        chk("ram_b write oe cycles", oe_cyc, 20);
        t1 = tr;
        clr();
        run_data(1'b0, 25'h1800007, 8'h00, t0, tr, e);
        chk("desel gap", t0 - t1, 2);
        chk("ram_b read latency", tr - t0, 29);
        chk("ram_b read rdata", data_rdata, 8'hA5);
        chk("ram_b read oe cycles", oe_cyc, 16);
        chk("ram_b read others low", f_low + a_low, 0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qspi_arbiter_ctrl.md
Name: qspi_arbiter_ctrl

Overview:
Single-byte quad-SPI master that shares one QSPI bus (flash, RAM A, RAM B; separate active-low selects) between two requesters: an instruction-fetch port (flash read-only) and a data port (flash read, RAM A/B read/write). It arbitrates between the ports, sequences command, address, dummy and data nibbles, generates qspi_clk at clk/2, and returns read bytes. It sits between the CPU core and the pads.

Parameters:
DUMMY_NIBBLES, 4, qspi_clk periods between the last address nibble and the first read-data nibble (reads only)
DESEL_CYCLES, 2, minimum clk cycles with all selects high between transactions
CMD_READ, 8'h0B, quad fast-read opcode
CMD_WRITE, 8'h02, write opcode

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fetch_req  in  1  fetch request; held until fetch_ready
fetch_addr  in  24  flash byte address
fetch_rdata  out  8  fetch read byte, valid while fetch_ready=1
fetch_ready  out  1  one-cycle completion pulse
data_req  in  1  data request; held until data_ready
data_we  in  1  1 = write
data_addr  in  25  bit24=0 flash; bit24=1,bit23=0 RAM A; bit24=1,bit23=1 RAM B
data_wdata  in  8  write byte
data_rdata  out  8  read byte, valid while data_ready=1
data_ready  out  1  one-cycle completion pulse
data_err  out  1  pulses with data_ready when a write targets flash
qspi_clk  out  1  SPI clock, idle low
qspi_data_out  out  4  nibble driven to the bus
qspi_data_oe  out  4  output enables, all-or-nothing
qspi_data_in  in  4  nibble from the bus
qspi_flash_select  out  1  active-low
qspi_ram_a_select  out  1  active-low
qspi_ram_b_select  out  1  active-low

Behaviour:
- Reset: all selects 1, qspi_clk 0, qspi_data_out 0, qspi_data_oe 0, both ready pulses 0, data_err 0, rdata outputs 0, FSM in IDLE, round-robin pointer set to favour data. Reset takes effect on the next edge even mid-transaction. The in-flight request is dropped and no ready pulse is issued; the requester re-issues after reset.
- Arbitration in IDLE:
  - If only one port is requesting, it is granted.
  - If both are requesting, the port not granted last wins (round-robin).
  - At grant, the address, we and wdata are latched. The requester must hold them stable until its ready pulse. Deasserting req early is illegal; the transaction still completes and the pulse still fires.
- Flash write (data_we=1, data_addr[24]=0): no bus activity. data_ready and data_err pulse 1 cycle after grant.
- Nibble timing: each nibble takes 2 clk cycles.
  - Phase L: qspi_clk=0, the controller updates qspi_data_out.
  - Phase H: qspi_clk=1; the slave samples on the rising edge.
  - Read data is sampled from qspi_data_in on the clk edge that ends phase H.
- FSM sequence: IDLE -> CMD (8 nibbles: opcode[7:4], opcode[3:0], addr[23:20] ... addr[3:0]; oe=4'hF) -> DUMMY (reads only; DUMMY_NIBBLES periods; oe=0) -> DATA (2 nibbles, high nibble first; oe=4'hF for writes, 0 for reads) -> DESEL (selects high, qspi_clk 0, oe 0, DESEL_CYCLES cycles) -> IDLE.
- Select behaviour: the selected chip's select goes low in the first CMD cycle and returns high on entry to DESEL. Only one select is ever low at a time.
- Opcode is CMD_READ for reads and CMD_WRITE for writes. The address sent is the latched address bits [23:0].
- Completion: the ready pulse is in the first DESEL cycle, with rdata registered and held until the next completion on that port.
- Latency, from the grant cycle (IDLE with req=1) to the ready pulse:
  - Read: 1 + 2*(8+DUMMY_NIBBLES+2) clk (29 at defaults).
  - Write: 1 + 2*10 = 21 clk.
- Back-to-back: the earliest next grant is DESEL_CYCLES after the ready pulse.
- Simultaneous events: a new req arriving in the same cycle as a ready pulse is not granted until IDLE.

Decomposition:
- Package qspi_pkg holds the opcode constants, FSM state enum (IDLE, CMD, DUMMY, DATA, DESEL, ERR) and target enum (FLASH, RAM_A, RAM_B).
- Sub-module qspi_rr_arbiter: 2-way round-robin with grant memory. The FSM, nibble counter and shifter stay in the top module.

Test Plan:
- Fetch read 0x000123, flash preloaded 0x5A at 0x123 -> qspi_flash_select low for 28 cycles, nibbles 0,B,0,0,0,1,2,3 on data_out, fetch_ready at grant+29, fetch_rdata=0x5A.
- Data write 0x1000010 = 0xC3, then read back -> ram_a only selected, opcode 02 then 0B, data_rdata=0xC3, other selects stay high throughout.
- fetch_req and data_req both asserted continuously -> grants alternate data, fetch, data, fetch; each port gets ready once per two transactions.
- Data write to 0x0000040 -> no select asserted, data_ready and data_err pulse at grant+1.
- rst asserted at cycle 10 of a RAM B read -> next cycle all selects 1, qspi_clk 0, no ready; a fresh read after reset returns the correct byte.
- Write 0xA5 to RAM B 0x1800007, read -> oe=F during write data, 0 during dummy/read; DESEL holds selects high exactly 2 cycles before the next grant.
